// File: rtl/qs_bank_sched.sv
// Bank scheduler for a three-stage (enqueue / sort / dequeue) pipeline over BANKS_N banks.
// Optional stall counters are compiled in by defining QS_BANK_SCHED_PERF_EN.
module qs_bank_sched #(
    parameter int BANKS_N = 2,
    parameter int CNT_W   = 16,
    localparam int IDX_W  = $clog2(BANKS_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_req,
    input  logic             srt_req,
    input  logic             deq_req,
    input  logic             enq_done,
    input  logic             srt_done,
    input  logic             deq_done,
    output logic             enq_gnt_r,
    output logic             srt_gnt_r,
    output logic             deq_gnt_r,
    output logic [IDX_W-1:0] enq_idx_r,
    output logic [IDX_W-1:0] srt_idx_r,
    output logic [IDX_W-1:0] deq_idx_r,
    output logic             empty_r,
    output logic             full_r,
    output logic             busy_r,
    output logic [CNT_W-1:0] enq_stall_cnt_r,
    output logic [CNT_W-1:0] deq_stall_cnt_r
);

    // bank state | meaning
    // B_EMPTY    | free, waiting for enqueue
    // B_ENQ      | owned by enqueue stage
    // B_LOADED   | filled, waiting for sort
    // B_SRT      | owned by sort stage
    // B_SORTED   | sorted, waiting for dequeue
    // B_DEQ      | owned by dequeue stage
    typedef enum logic [2:0] {B_EMPTY, B_ENQ, B_LOADED, B_SRT, B_SORTED, B_DEQ} bank_st_t;

    // Stage index: 0 = enq, 1 = srt, 2 = deq
    function automatic bank_st_t pre_st(input int s);
        case (s)
            0:       return B_EMPTY;
            1:       return B_LOADED;
            default: return B_SORTED;
        endcase
    endfunction

    function automatic bank_st_t own_st(input int s);
        case (s)
            0:       return B_ENQ;
            1:       return B_SRT;
            default: return B_DEQ;
        endcase
    endfunction

    function automatic bank_st_t post_st(input int s);
        case (s)
            0:       return B_LOADED;
            1:       return B_SORTED;
            default: return B_EMPTY;
        endcase
    endfunction

    bank_st_t         bank_q [BANKS_N];
    bank_st_t         bank_d [BANKS_N];
    logic [2:0]       gnt_q, gnt_d;
    logic [IDX_W-1:0] ptr_q [3];
    logic [IDX_W-1:0] ptr_d [3];
    logic [IDX_W-1:0] idx_q [3];
    logic [IDX_W-1:0] idx_d [3];
    logic [2:0]       req_v, done_v;
    logic             empty_d, full_d;

    assign req_v  = {deq_req, srt_req, enq_req};
    assign done_v = {deq_done, srt_done, enq_done};

    // Stages only ever touch the bank at their own pointer, so their updates never collide.
    always_comb begin
        for (int b = 0; b < BANKS_N; b++) bank_d[b] = bank_q[b];
        gnt_d = gnt_q;
        for (int s = 0; s < 3; s++) begin
            ptr_d[s] = ptr_q[s];
            idx_d[s] = idx_q[s];
        end
        for (int s = 0; s < 3; s++) begin
            if (gnt_q[s]) begin
                if (done_v[s]) begin
                    bank_d[idx_q[s]] = post_st(s);
                    gnt_d[s]         = 1'b0;
                    ptr_d[s]         = ptr_q[s] + 1'b1;
                end
            end else if (req_v[s] && bank_q[ptr_q[s]] == pre_st(s)) begin
                bank_d[ptr_q[s]] = own_st(s);
                gnt_d[s]         = 1'b1;
                idx_d[s]         = ptr_q[s];
            end
        end
        empty_d = 1'b1;
        full_d  = 1'b1;
        for (int b = 0; b < BANKS_N; b++) begin
            if (bank_d[b] == B_EMPTY) full_d  = 1'b0;
            else                      empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < BANKS_N; b++) bank_q[b] <= B_EMPTY;
            for (int s = 0; s < 3; s++) begin
                ptr_q[s] <= '0;
                idx_q[s] <= '0;
            end
            gnt_q   <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            for (int b = 0; b < BANKS_N; b++) bank_q[b] <= bank_d[b];
            for (int s = 0; s < 3; s++) begin
                ptr_q[s] <= ptr_d[s];
                idx_q[s] <= idx_d[s];
            end
            gnt_q   <= gnt_d;
            empty_r <= empty_d;
            full_r  <= full_d;
            busy_r  <= |gnt_d;
        end
    end

    assign enq_gnt_r = gnt_q[0];
    assign srt_gnt_r = gnt_q[1];
    assign deq_gnt_r = gnt_q[2];
    assign enq_idx_r = idx_q[0];
    assign srt_idx_r = idx_q[1];
    assign deq_idx_r = idx_q[2];

`ifdef QS_BANK_SCHED_PERF_EN
    // A stall is a cycle with a pending request that the grant logic turns down.
    logic enq_stall, deq_stall;
    assign enq_stall = enq_req && !gnt_q[0] && (bank_q[ptr_q[0]] != B_EMPTY);
    assign deq_stall = deq_req && !gnt_q[2] && (bank_q[ptr_q[2]] != B_SORTED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enq_stall_cnt_r <= '0;
            deq_stall_cnt_r <= '0;
        end else begin
            if (enq_stall && enq_stall_cnt_r != '1) enq_stall_cnt_r <= enq_stall_cnt_r + 1'b1;
            if (deq_stall && deq_stall_cnt_r != '1) deq_stall_cnt_r <= deq_stall_cnt_r + 1'b1;
        end
    end
`else
    assign enq_stall_cnt_r = '0;
    assign deq_stall_cnt_r = '0;
`endif

endmodule

// File: tb/tb_qs_bank_sched.sv
// Scoreboard bench for qs_bank_sched (BANKS_N=2): expected grant indices are queued per stage
// and checked by a monitor on each grant rising edge; flags and counters are checked inline.
module tb_qs_bank_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        enq_req, srt_req, deq_req;
    logic        enq_done, srt_done, deq_done;
    logic        enq_gnt_r, srt_gnt_r, deq_gnt_r;
    logic        enq_idx_r, srt_idx_r, deq_idx_r;
    logic        empty_r, full_r, busy_r;
    logic [15:0] enq_stall_cnt_r, deq_stall_cnt_r;

    int errs  = 0;
    int n_chk = 0;
    int q_enq[$];
    int q_srt[$];
    int q_deq[$];
    logic [2:0] prev_g = 3'b000;
    logic [2:0] cur_g;

`ifdef QS_BANK_SCHED_PERF_EN
    localparam int EXP_ENQ_STALL = 5;
    localparam int EXP_DEQ_STALL = 3;
`else
    localparam int EXP_ENQ_STALL = 0;
    localparam int EXP_DEQ_STALL = 0;
`endif

    qs_bank_sched #(.BANKS_N(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .enq_req(enq_req), .srt_req(srt_req), .deq_req(deq_req),
        .enq_done(enq_done), .srt_done(srt_done), .deq_done(deq_done),
        .enq_gnt_r(enq_gnt_r), .srt_gnt_r(srt_gnt_r), .deq_gnt_r(deq_gnt_r),
        .enq_idx_r(enq_idx_r), .srt_idx_r(srt_idx_r), .deq_idx_r(deq_idx_r),
        .empty_r(empty_r), .full_r(full_r), .busy_r(busy_r),
        .enq_stall_cnt_r(enq_stall_cnt_r), .deq_stall_cnt_r(deq_stall_cnt_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cur_idx(input int s);
        case (s)
            0:       return int'(enq_idx_r);
            1:       return int'(srt_idx_r);
            default: return int'(deq_idx_r);
        endcase
    endfunction

    function automatic logic get_gnt(input int s);
        case (s)
            0:       return enq_gnt_r;
            1:       return srt_gnt_r;
            default: return deq_gnt_r;
        endcase
    endfunction

    task automatic push_exp(input int s, input int idx);
        case (s)
            0:       q_enq.push_back(idx);
            1:       q_srt.push_back(idx);
            default: q_deq.push_back(idx);
        endcase
    endtask

    task automatic mon_pop(input int s, input int act);
        int  e;
        bit  have;
        e    = 0;
        have = 1'b0;
        case (s)
            0:       if (q_enq.size() > 0) begin have = 1'b1; e = q_enq.pop_front(); end
            1:       if (q_srt.size() > 0) begin have = 1'b1; e = q_srt.pop_front(); end
            default: if (q_deq.size() > 0) begin have = 1'b1; e = q_deq.pop_front(); end
        endcase
        n_chk++;
        if (!have) begin
            errs++;
            $display("FAIL unexpected_grant stage%0d: got idx %0d expected no grant (t=%0t)", s, act, $time);
        end else if (act != e) begin
            errs++;
            $display("FAIL grant_idx stage%0d: got %0d expected %0d (t=%0t)", s, act, e, $time);
        end
    endtask

    always @(negedge clk) begin
        cur_g = {deq_gnt_r, srt_gnt_r, enq_gnt_r};
        for (int s = 0; s < 3; s++)
            if (cur_g[s] && !prev_g[s]) mon_pop(s, cur_idx(s));
        prev_g = cur_g;
    end

    task automatic set_req(input int s, input logic v);
        case (s)
            0:       enq_req = v;
            1:       srt_req = v;
            default: deq_req = v;
        endcase
    endtask

    task automatic set_done(input int s, input logic v);
        case (s)
            0:       enq_done = v;
            1:       srt_done = v;
            default: deq_done = v;
        endcase
    endtask

    // Called at a negedge; returns at the negedge on which the grant is visible.
    task automatic acquire(input int s, input int idx);
        logic got;
        got = 1'b0;
        push_exp(s, idx);
        set_req(s, 1'b1);
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = get_gnt(s);
        end
        set_req(s, 1'b0);
        chk($sformatf("grant_seen stage%0d", s), int'(got), 1);
    endtask

    task automatic release_bank(input int s);
        set_done(s, 1'b1);
        @(negedge clk);
        set_done(s, 1'b0);
        chk($sformatf("gnt_cleared stage%0d", s), int'(get_gnt(s)), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        enq_req = 0; srt_req = 0; deq_req = 0;
        enq_done = 0; srt_done = 0; deq_done = 0;
        repeat (2) @(negedge clk);
        chk("rst_empty", int'(empty_r), 1);
        chk("rst_full", int'(full_r), 0);
        chk("rst_busy", int'(busy_r), 0);
        chk("rst_gnts", int'({enq_gnt_r, srt_gnt_r, deq_gnt_r}), 0);
        chk("rst_idx", int'({enq_idx_r, srt_idx_r, deq_idx_r}), 0);
        chk("rst_enq_stall", int'(enq_stall_cnt_r), 0);
        rst = 1'b1;
        @(negedge clk);

        // First grant and full pipeline on bank 0, then three more rounds to exercise wrap
        acquire(0, 0);
        chk("grant_empty", int'(empty_r), 0);
        chk("grant_busy", int'(busy_r), 1);
        chk("grant_full", int'(full_r), 0);
        release_bank(0);
        acquire(1, 0);
        release_bank(1);
        acquire(2, 0);
        release_bank(2);
        chk("pipe_empty", int'(empty_r), 1);
        chk("pipe_busy", int'(busy_r), 0);
        for (int r = 1; r < 4; r++) begin
            acquire(0, r % 2);
            release_bank(0);
            acquire(1, r % 2);
            release_bank(1);
            acquire(2, r % 2);
            release_bank(2);
        end
        chk("wrap_empty", int'(empty_r), 1);

        // Fill both banks, then stall enq and deq
        acquire(0, 0);
        release_bank(0);
        acquire(0, 1);
        release_bank(0);
        chk("fill_full", int'(full_r), 1);
        chk("fill_empty", int'(empty_r), 0);
        enq_req = 1'b1;
        repeat (5) @(negedge clk);
        enq_req = 1'b0;
        chk("full_no_enq_gnt", int'(enq_gnt_r), 0);
        chk("enq_stall_cnt", int'(enq_stall_cnt_r), EXP_ENQ_STALL);
        deq_req = 1'b1;
        repeat (3) @(negedge clk);
        deq_req = 1'b0;
        chk("no_sorted_deq_gnt", int'(deq_gnt_r), 0);
        chk("deq_stall_cnt", int'(deq_stall_cnt_r), EXP_DEQ_STALL);

        rst = 1'b0;
        #1;
        chk("rst2_empty", int'(empty_r), 1);
        chk("rst2_full", int'(full_r), 0);
        chk("rst2_stall", int'(enq_stall_cnt_r) + int'(deq_stall_cnt_r), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Simultaneous enq_done on bank1 and deq_done on bank0
        acquire(0, 0);
        release_bank(0);
        acquire(1, 0);
        release_bank(1);
        acquire(2, 0);
        acquire(0, 1);
        chk("sim_busy_before", int'(busy_r), 1);
        enq_done = 1'b1;
        deq_done = 1'b1;
        @(negedge clk);
        enq_done = 1'b0;
        deq_done = 1'b0;
        chk("sim_gnts_clear", int'({enq_gnt_r, deq_gnt_r}), 0);
        chk("sim_busy", int'(busy_r), 0);
        chk("sim_empty", int'(empty_r), 0);
        chk("sim_full", int'(full_r), 0);
        acquire(1, 1);
        acquire(0, 0);
        chk("sim_full_after", int'(full_r), 1);

        // Reset while sort owns a bank, then a stray srt_done
        chk("pre_rst_srt_gnt", int'(srt_gnt_r), 1);
        rst = 1'b0;
        #1;
        chk("rst3_srt_gnt", int'(srt_gnt_r), 0);
        chk("rst3_empty", int'(empty_r), 1);
        chk("rst3_busy", int'(busy_r), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        srt_done = 1'b1;
        @(negedge clk);
        srt_done = 1'b0;
        @(negedge clk);
        chk("stray_done_gnt", int'(srt_gnt_r), 0);
        chk("stray_done_empty", int'(empty_r), 1);
        chk("stray_done_busy", int'(busy_r), 0);
        acquire(0, 0);
        release_bank(0);
        repeat (2) @(negedge clk);

        chk("queues_drained", q_enq.size() + q_srt.size() + q_deq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, n_chk);
        $finish;
    end
endmodule
